// File: rtl/pcie_tlp_pkg.sv
// Shared TLP definitions for the PCIe endpoint RX decoder and TX generator.
// Holds fmt_type codes, header-beat bit offsets and the RX state encoding.
package pcie_tlp_pkg;

    localparam logic [6:0] MRD32 = 7'b00_00000;
    localparam logic [6:0] MRD64 = 7'b01_00000;
    localparam logic [6:0] MWR32 = 7'b10_00000;
    localparam logic [6:0] MWR64 = 7'b11_00000;
    localparam logic [6:0] CPL   = 7'b00_01010;
    localparam logic [6:0] CPLD  = 7'b10_01010;

    localparam int FMT_TYPE_LSB = 24;
    localparam int TC_LSB       = 20;
    localparam int TD_BIT       = 15;
    localparam int EP_BIT       = 14;
    localparam int ATTR_LSB     = 12;
    localparam int LEN_LSB      = 0;
    localparam int FBE_LSB      = 32;
    localparam int LBE_LSB      = 36;
    localparam int TAG_LSB      = 40;
    localparam int RID_LSB      = 48;
    localparam int ADDR3_LSB    = 66;
    localparam int ADDR4_LSB    = 98;
    localparam int DATA3_LSB    = 96;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPL_PEND,
        ST_CPL_CLR,
        ST_WR_DATA,
        ST_WR_ISSUE,
        ST_DRAIN
    } rx_state_e;

    typedef struct packed {
        logic [6:0]  fmt_type;
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [3:0]  fbe;
        logic [3:0]  lbe;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [29:0] addr3;
        logic [29:0] addr4;
        logic [31:0] data3;
    } tlp_hdr_t;

endpackage

// File: rtl/pcie_tlp_hdr_fields.sv
// Combinational field extractor for a 128-bit TLP header beat.
// Both 3DW and 4DW address positions are presented; the caller picks.
module pcie_tlp_hdr_fields
    import pcie_tlp_pkg::*;
(
    input  logic [127:0] tdata,
    output tlp_hdr_t     hdr
);

    assign hdr.fmt_type = tdata[FMT_TYPE_LSB +: 7];
    assign hdr.tc       = tdata[TC_LSB +: 3];
    assign hdr.td       = tdata[TD_BIT];
    assign hdr.ep       = tdata[EP_BIT];
    assign hdr.attr     = tdata[ATTR_LSB +: 2];
    assign hdr.len      = tdata[LEN_LSB +: 10];
    assign hdr.fbe      = tdata[FBE_LSB +: 4];
    assign hdr.lbe      = tdata[LBE_LSB +: 4];
    assign hdr.tag      = tdata[TAG_LSB +: 8];
    assign hdr.rid      = tdata[RID_LSB +: 16];
    assign hdr.addr3    = tdata[ADDR3_LSB +: 30];
    assign hdr.addr4    = tdata[ADDR4_LSB +: 30];
    assign hdr.data3    = tdata[DATA3_LSB +: 32];

    // reserved bits and the upper 4DW address are not decoded
    logic unused_bits;
    assign unused_bits = ^{tdata[31], tdata[23], tdata[19:16],
                           tdata[11:10], tdata[65:64]};

endmodule

// File: rtl/pcie_rx_req_decoder.sv
// Single-DW MRd/MWr decoder on the PCIe RX AXI-Stream; drains the rest.
// Define PCIE_RX_MEM64_EN to also decode 4DW MRd64/MWr64.
module pcie_rx_req_decoder
    import pcie_tlp_pkg::*;
#(
    parameter int P_DATA_WIDTH = 128,
    parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [P_DATA_WIDTH-1:0] m_axis_rx_tdata,
    input  logic [P_KEEP_WIDTH-1:0] m_axis_rx_tkeep,
    input  logic                    m_axis_rx_tlast,
    input  logic                    m_axis_rx_tvalid,
    output logic                    m_axis_rx_tready,
    output logic                    req_compl,
    output logic                    req_compl_wd,
    input  logic                    compl_done,
    output logic [2:0]              req_tc,
    output logic                    req_td,
    output logic                    req_ep,
    output logic [1:0]              req_attr,
    output logic [9:0]              req_len,
    output logic [15:0]             req_rid,
    output logic [7:0]              req_tag,
    output logic [7:0]              req_be,
    output logic [31:0]             req_addr,
    output logic                    wr_en,
    output logic [31:0]             wr_addr,
    output logic [3:0]              wr_be,
    output logic [31:0]             wr_data,
    input  logic                    wr_busy,
    output logic [7:0]              unsupported_cnt
);

    rx_state_e state_q, state_d;
    tlp_hdr_t  hdr;
    logic      rdy_q;
    logic      drain_after_q;
    logic      beat_acc, hdr_acc;
    logic      len_ok, is_rd, is_wr3, is_wr4, is_unsup;
    logic [31:0] hdr_addr;

    pcie_tlp_hdr_fields u_fields (
        .tdata (m_axis_rx_tdata),
        .hdr   (hdr)
    );

    // rdy_q keeps tready low through reset and the first edge after it
    assign m_axis_rx_tready = rdy_q && (state_q == ST_IDLE ||
                                        state_q == ST_WR_DATA ||
                                        state_q == ST_DRAIN);
    assign beat_acc = m_axis_rx_tvalid && m_axis_rx_tready;
    assign hdr_acc  = beat_acc && (state_q == ST_IDLE);

    assign len_ok = (hdr.len == 10'd1) && !hdr.ep;
    assign is_wr3 = len_ok && (hdr.fmt_type == MWR32);
`ifdef PCIE_RX_MEM64_EN
    assign is_rd  = len_ok && (hdr.fmt_type == MRD32 ||
                               hdr.fmt_type == MRD64);
    assign is_wr4 = len_ok && (hdr.fmt_type == MWR64);
`else
    assign is_rd  = len_ok && (hdr.fmt_type == MRD32);
    assign is_wr4 = 1'b0;
`endif
    assign is_unsup = !(is_rd || is_wr3 || is_wr4);

    // fmt bit 0 (fmt_type[5]) selects the 4DW address position
    assign hdr_addr = hdr.fmt_type[5] ? {hdr.addr4, 2'b00}
                                      : {hdr.addr3, 2'b00};

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (hdr_acc) begin
                    if (is_rd)
                        state_d = ST_CPL_PEND;
                    else if (is_wr3)
                        state_d = ST_WR_ISSUE;
                    else if (is_wr4)
                        state_d = ST_WR_DATA;
                    else if (!m_axis_rx_tlast)
                        state_d = ST_DRAIN;
                end
            end
            ST_CPL_PEND: begin
                if (compl_done)
                    state_d = ST_CPL_CLR;
            end
            ST_CPL_CLR: begin
                if (!compl_done)
                    state_d = ST_IDLE;
            end
`ifdef PCIE_RX_MEM64_EN
            ST_WR_DATA: begin
                if (beat_acc)
                    state_d = ST_WR_ISSUE;
            end
`endif
            ST_WR_ISSUE: begin
                wr_en = !wr_busy;
                if (!wr_busy)
                    state_d = drain_after_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (beat_acc && m_axis_rx_tlast)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q         <= ST_IDLE;
            rdy_q           <= 1'b0;
            drain_after_q   <= 1'b0;
            req_compl       <= 1'b0;
            req_compl_wd    <= 1'b0;
            req_tc          <= '0;
            req_td          <= 1'b0;
            req_ep          <= 1'b0;
            req_attr        <= '0;
            req_len         <= '0;
            req_rid         <= '0;
            req_tag         <= '0;
            req_be          <= '0;
            req_addr        <= '0;
            wr_addr         <= '0;
            wr_be           <= '0;
            wr_data         <= '0;
            unsupported_cnt <= '0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= 1'b1;
            req_compl <= hdr_acc && is_rd;
            if (hdr_acc && is_rd) begin
                req_compl_wd <= 1'b1;
                req_tc       <= hdr.tc;
                req_td       <= hdr.td;
                req_ep       <= hdr.ep;
                req_attr     <= hdr.attr;
                req_len      <= hdr.len;
                req_rid      <= hdr.rid;
                req_tag      <= hdr.tag;
                req_be       <= {hdr.lbe, hdr.fbe};
                req_addr     <= hdr_addr;
            end
            if (hdr_acc && (is_wr3 || is_wr4)) begin
                wr_addr       <= hdr_addr;
                wr_be         <= hdr.fbe;
                drain_after_q <= 1'b0;
                if (is_wr3)
                    wr_data <= hdr.data3;
            end
            // 4DW write payload arrives in the second beat
            if (state_q == ST_WR_DATA && beat_acc) begin
                wr_data       <= m_axis_rx_tdata[31:0];
                drain_after_q <= !m_axis_rx_tlast;
            end
            if (hdr_acc && is_unsup && unsupported_cnt != 8'hFF)
                unsupported_cnt <= unsupported_cnt + 8'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^m_axis_rx_tkeep;

endmodule

// File: tb/tb_pcie_rx_req_decoder.sv
// Scoreboard bench for pcie_rx_req_decoder: directed TLPs, queued expectations.
// Expectations follow PCIE_RX_MEM64_EN when the bench is built with it.
module tb_pcie_rx_req_decoder;
    import pcie_tlp_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic [127:0] m_axis_rx_tdata = '0;
    logic [15:0]  m_axis_rx_tkeep = 16'hFFFF;
    logic         m_axis_rx_tlast = 1'b0;
    logic         m_axis_rx_tvalid = 1'b0;
    logic         m_axis_rx_tready;
    logic         req_compl, req_compl_wd;
    logic         compl_done = 1'b0;
    logic [2:0]   req_tc;
    logic         req_td, req_ep;
    logic [1:0]   req_attr;
    logic [9:0]   req_len;
    logic [15:0]  req_rid;
    logic [7:0]   req_tag, req_be;
    logic [31:0]  req_addr;
    logic         wr_en;
    logic [31:0]  wr_addr, wr_data;
    logic [3:0]   wr_be;
    logic         wr_busy = 1'b0;
    logic [7:0]   unsupported_cnt;

    pcie_rx_req_decoder dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .m_axis_rx_tdata  (m_axis_rx_tdata),
        .m_axis_rx_tkeep  (m_axis_rx_tkeep),
        .m_axis_rx_tlast  (m_axis_rx_tlast),
        .m_axis_rx_tvalid (m_axis_rx_tvalid),
        .m_axis_rx_tready (m_axis_rx_tready),
        .req_compl        (req_compl),
        .req_compl_wd     (req_compl_wd),
        .compl_done       (compl_done),
        .req_tc           (req_tc),
        .req_td           (req_td),
        .req_ep           (req_ep),
        .req_attr         (req_attr),
        .req_len          (req_len),
        .req_rid          (req_rid),
        .req_tag          (req_tag),
        .req_be           (req_be),
        .req_addr         (req_addr),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_be            (wr_be),
        .wr_data          (wr_data),
        .wr_busy          (wr_busy),
        .unsupported_cnt  (unsupported_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  be;
        logic [7:0]  tag;
        logic [15:0] rid;
    } exp_t;

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor: every strobe the DUT presents must match the queue head
    always @(negedge i_clk) begin
        if (i_rst_n && (req_compl || wr_en)) begin
            exp_t e;
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: req_compl=%0b wr_en=%0b expected none",
                         req_compl, wr_en);
            end else begin
                e = sbq.pop_front();
                if (e.is_wr) begin
                    check("wr_en_strobe", {31'd0, wr_en}, 32'd1);
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                    check("wr_be", {28'd0, wr_be}, {24'd0, e.be});
                end else begin
                    check("req_compl_strobe", {31'd0, req_compl}, 32'd1);
                    check("req_addr", req_addr, e.addr);
                    check("req_tag", {24'd0, req_tag}, {24'd0, e.tag});
                    check("req_be", {24'd0, req_be}, {24'd0, e.be});
                    check("req_rid", {16'd0, req_rid}, {16'd0, e.rid});
                    check("req_compl_wd", {31'd0, req_compl_wd}, 32'd1);
                    check("req_len", {22'd0, req_len}, 32'd1);
                end
            end
        end
    end

    function automatic logic [127:0] mk_hdr(
        input logic [6:0] ft, input logic [9:0] len, input logic ep,
        input logic [7:0] tag, input logic [15:0] rid, input logic [7:0] be,
        input logic [63:0] addr, input logic [31:0] data);
        logic [127:0] d;
        d = '0;
        d[30:24] = ft;
        d[14]    = ep;
        d[9:0]   = len;
        d[39:32] = be;
        d[47:40] = tag;
        d[63:48] = rid;
        if (ft[5]) begin
            d[95:64]  = addr[63:32];
            d[127:98] = addr[31:2];
        end else begin
            d[95:66]   = addr[31:2];
            d[127:96]  = data;
        end
        return d;
    endfunction

    // returns one cycle after the acceptance edge, at posedge+1
    task automatic send_beat(input logic [127:0] d, input logic last);
        bit acc;
        int n;
        m_axis_rx_tdata  = d;
        m_axis_rx_tlast  = last;
        m_axis_rx_tvalid = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 200) begin
            @(negedge i_clk);
            acc = m_axis_rx_tready;
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL beat_accept_timeout: tready=%0b expected 1", m_axis_rx_tready);
        end
        m_axis_rx_tvalid = 1'b0;
        m_axis_rx_tlast  = 1'b0;
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [7:0] tag,
                           input logic [15:0] rid, input logic [7:0] be);
        exp_t e;
        e = '{is_wr: 1'b0, addr: a, data: 32'd0, be: be, tag: tag, rid: rid};
        sbq.push_back(e);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
        exp_t e;
        e = '{is_wr: 1'b1, addr: a, data: d, be: {4'd0, be}, tag: 8'd0, rid: 16'd0};
        sbq.push_back(e);
    endtask

    // called in the cycle after MRd acceptance
    task automatic serve_cpl(input string tname);
        repeat (2) begin
            @(negedge i_clk);
            check({tname, "_tready_pend"}, {31'd0, m_axis_rx_tready}, 32'd0);
        end
        @(posedge i_clk); #1 compl_done = 1'b1;
        @(negedge i_clk);
        check({tname, "_tready_done"}, {31'd0, m_axis_rx_tready}, 32'd0);
        @(posedge i_clk); #1 compl_done = 1'b0;
        @(negedge i_clk);
        check({tname, "_tready_clr"}, {31'd0, m_axis_rx_tready}, 32'd0);
        @(negedge i_clk);
        check({tname, "_tready_idle"}, {31'd0, m_axis_rx_tready}, 32'd1);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        #2;
        check("rst_tready", {31'd0, m_axis_rx_tready}, 32'd0);
        check("rst_req_compl", {31'd0, req_compl}, 32'd0);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_cnt", {24'd0, unsupported_cnt}, 32'd0);
        check("rst_req_addr", req_addr, 32'd0);
        @(negedge i_clk); @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 check("rel_tready_before_clk", {31'd0, m_axis_rx_tready}, 32'd0);
        @(posedge i_clk); #1;
        check("rel_tready_after_clk", {31'd0, m_axis_rx_tready}, 32'd1);

        // MRd32
        push_rd(32'h0000_1004, 8'h12, 16'hABCD, 8'h0F);
        send_beat(mk_hdr(MRD32, 10'd1, 1'b0, 8'h12, 16'hABCD, 8'h0F,
                         64'h1004, 32'd0), 1'b1);
        serve_cpl("mrd1");

        // MWr32, no backpressure: strobe in N+1, IDLE at N+2
        push_wr(32'h24, 32'h1234_5678, 4'hF);
        send_beat(mk_hdr(MWR32, 10'd1, 1'b0, 8'h01, 16'h0001, 8'h0F,
                         64'h24, 32'h1234_5678), 1'b1);
        @(negedge i_clk);
        check("mwr_fast_wr_en", {31'd0, wr_en}, 32'd1);
        @(negedge i_clk);
        check("mwr_fast_wr_en_off", {31'd0, wr_en}, 32'd0);
        check("mwr_fast_idle", {31'd0, m_axis_rx_tready}, 32'd1);
        @(posedge i_clk); #1;

        // MWr32 with wr_busy for 3 cycles
        wr_busy = 1'b1;
        push_wr(32'h20, 32'hDEAD_BEEF, 4'h3);
        send_beat(mk_hdr(MWR32, 10'd1, 1'b0, 8'h02, 16'h0001, 8'h03,
                         64'h20, 32'hDEAD_BEEF), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("busy_wr_en_low", {31'd0, wr_en}, 32'd0);
        end
        @(posedge i_clk); #1 wr_busy = 1'b0;
        @(negedge i_clk);
        check("busy_wr_en_pulse", {31'd0, wr_en}, 32'd1);
        @(negedge i_clk);
        check("busy_wr_en_once", {31'd0, wr_en}, 32'd0);
        @(posedge i_clk); #1;

        // three-beat CplD then MRd32
        send_beat(mk_hdr(CPLD, 10'd2, 1'b0, 8'h05, 16'h0100, 8'h00,
                         64'h0, 32'h0), 1'b0);
        exp_cnt++;
        #3 check("cpld_cnt", {24'd0, unsupported_cnt}, exp_cnt);
        send_beat({4{32'hA5A5_0001}}, 1'b0);
        send_beat({4{32'hA5A5_0002}}, 1'b1);
        push_rd(32'h0000_0208, 8'h34, 16'h1111, 8'h0F);
        send_beat(mk_hdr(MRD32, 10'd1, 1'b0, 8'h34, 16'h1111, 8'h0F,
                         64'h208, 32'd0), 1'b1);
        serve_cpl("mrd2");
        check("cpld_cnt_after", {24'd0, unsupported_cnt}, exp_cnt);

        // MWr64 to 0x1_0000_0040
`ifdef PCIE_RX_MEM64_EN
        push_wr(32'h40, 32'h55, 4'hF);
`else
        exp_cnt++;
`endif
        send_beat(mk_hdr(MWR64, 10'd1, 1'b0, 8'h06, 16'h0001, 8'h0F,
                         64'h1_0000_0040, 32'd0), 1'b0);
        send_beat({96'd0, 32'h55}, 1'b1);
        repeat (3) @(posedge i_clk);
        #1 check("mwr64_cnt", {24'd0, unsupported_cnt}, exp_cnt);

        // poisoned MRd32
        send_beat(mk_hdr(MRD32, 10'd1, 1'b1, 8'h07, 16'h0001, 8'h0F,
                         64'h300, 32'd0), 1'b1);
        exp_cnt++;
        #3 check("poison_cnt", {24'd0, unsupported_cnt}, exp_cnt);

        // 300 MRd32 with len=2
        for (int i = 0; i < 300; i++) begin
            send_beat(mk_hdr(MRD32, 10'd2, 1'b0, i[7:0], 16'h0002, 8'hFF,
                             64'h400, 32'd0), 1'b1);
            if (exp_cnt < 255)
                exp_cnt++;
        end
        #3 check("sat_cnt", {24'd0, unsupported_cnt}, exp_cnt);
        check("sat_cnt_255", {24'd0, unsupported_cnt}, 32'd255);

        // reset while in CPL_PEND
        push_rd(32'h0000_0500, 8'h44, 16'h2222, 8'h0F);
        send_beat(mk_hdr(MRD32, 10'd1, 1'b0, 8'h44, 16'h2222, 8'h0F,
                         64'h500, 32'd0), 1'b1);
        @(posedge i_clk); #3;
        i_rst_n = 1'b0;
        #1;
        check("arst_tready", {31'd0, m_axis_rx_tready}, 32'd0);
        check("arst_req_addr", req_addr, 32'd0);
        check("arst_req_tag", {24'd0, req_tag}, 32'd0);
        check("arst_req_wd", {31'd0, req_compl_wd}, 32'd0);
        check("arst_wr_addr", wr_addr, 32'd0);
        check("arst_cnt", {24'd0, unsupported_cnt}, 32'd0);
        @(negedge i_clk); @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        push_rd(32'h0000_0604, 8'h55, 16'h3333, 8'h0F);
        send_beat(mk_hdr(MRD32, 10'd1, 1'b0, 8'h55, 16'h3333, 8'h0F,
                         64'h604, 32'd0), 1'b1);
        serve_cpl("mrd3");

        repeat (4) @(posedge i_clk);
        #1 check("sb_empty", sbq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pcie_rx_req_decoder.md
# pcie_rx_req_decoder

- Upstream request decoder for the PCIe endpoint.
- Consumes the 128-bit receive AXI-Stream from the PCIe hard core and decodes single-DW memory read and write requests.
- Read requests become a one-cycle completion request plus held header fields for the TX completion/DMA-request generator. That generator answers with `compl_done`.
- Write requests become a one-cycle register write strobe. Every other TLP is drained and counted.

## Interface
- `P_DATA_WIDTH`, 128: receive stream width. Only 128 is supported.
- `P_KEEP_WIDTH`, `P_DATA_WIDTH/8`: tkeep width.

- `i_clk` in 1: single clock domain.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `m_axis_rx_tdata` in 128: TLP beat.
- `m_axis_rx_tkeep` in 16: byte enables. Accepted but not used for decode.
- `m_axis_rx_tlast` in 1: last beat of TLP.
- `m_axis_rx_tvalid` in 1: beat valid.
- `m_axis_rx_tready` out 1: beat accept.
- `req_compl` out 1: one-cycle pulse requesting a completion.
- `req_compl_wd` out 1: completion carries data. Always 1 for MRd.
- `compl_done` in 1: TX stage has taken the request. Stays high until its beat is sent.
- `req_tc` out 3, `req_td` out 1, `req_ep` out 1, `req_attr` out 2, `req_len` out 10, `req_rid` out 16, `req_tag` out 8: header fields of the MRd being completed.
- `req_be` out 8: {last BE, first BE}.
- `req_addr` out 32: DW-aligned byte address. Bits [1:0] = 0.
- `wr_en` out 1: write strobe.
- `wr_addr` out 32, `wr_be` out 4, `wr_data` out 32: write payload.
- `wr_busy` in 1: register file cannot accept a write.
- `unsupported_cnt` out 8: saturating count of discarded TLPs.

## Operation
- Field offsets in header beat:
  - fmt_type `tdata[30:24]`, tc `[22:20]`, td `[15]`, ep `[14]`, attr `[13:12]`, len `[9:0]`.
  - first BE `[35:32]`, last BE `[39:36]`, tag `[47:40]`, requester ID `[63:48]`.
  - 3DW: addr[31:2] = `[95:66]`, write data = `[127:96]`.
  - 4DW: addr[31:2] = `[127:98]`; upper 32 address bits are ignored; write data is beat 2 `[31:0]`.
- Supported TLPs:
  - MRd32 (7'b00_00000) and MWr32 (7'b10_00000), both with len==1 and ep==0.
  - MRd64/MWr64 only as listed under Configuration.
- Anything else counts as unsupported. This includes Cpl/CplD, wrong length and poisoned TLPs.
- `unsupported_cnt` increments once per unsupported TLP, in the cycle after its header is accepted. It saturates at 255.
- States:
  - IDLE: tready=1. A header beat is accepted when tvalid&&tready.
    - MRd → CPL_PEND and pulse `req_compl`.
    - MWr32 → WR_ISSUE.
    - MWr64 → WR_DATA.
    - Unsupported without tlast → DRAIN; with tlast → stay in IDLE.
  - CPL_PEND: tready=0. Wait for `compl_done`=1 → CPL_CLR.
  - CPL_CLR: tready=0. Wait for `compl_done`=0 → IDLE. This prevents a second `req_compl` while the TX stage is still busy.
  - WR_DATA: tready=1. Latch data from the next accepted beat → WR_ISSUE. If that beat lacks tlast, go to DRAIN after the write instead of IDLE.
  - WR_ISSUE: tready=0. `wr_en` = !`wr_busy`, decoded combinationally. Leave when !`wr_busy`.
  - DRAIN: tready=1. Discard beats; tlast → IDLE.
- `req_*` fields are registered at MRd header acceptance and held until the next MRd. `req_compl_wd` is held at 1.
- `wr_*` payload is registered and held until the next write.

## Timing
- Reset values:
  - All outputs 0, `unsupported_cnt` 0, state IDLE.
  - `m_axis_rx_tready` is 0 while `i_rst_n`=0 and 1 from the first clock after release.
- `tready` is decoded from the state register only. There is no combinational path from tvalid.
- MRd header accepted at edge N:
  - `req_compl`=1 and fields valid during cycle N+1 only.
  - The earliest next acceptance is the cycle after `compl_done` falls.
- MWr32 accepted at edge N with `wr_busy`=0: `wr_en`=1 for exactly cycle N+1; IDLE at N+2.
- While `wr_busy`=1, `wr_en` stays 0 and payload is held; `wr_en` pulses in the first cycle `wr_busy`=0.
- `compl_done` already high on entry to CPL_PEND: move to CPL_CLR next cycle.
- Asynchronous reset mid-TLP: the partial TLP is lost, no strobe is issued, and the decoder restarts in IDLE. The next beat is treated as a header.

## Configuration
- `PCIE_RX_MEM64_EN` defined: MRd64 (7'b01_00000) and MWr64 (7'b11_00000) with len==1 are decoded, and the WR_DATA state exists.
- Undefined: all 4DW TLPs are unsupported; they are drained and counted.

## Structure
- Shared package `pcie_tlp_pkg`, also imported by the TX generator:
  - fmt_type constants: MRD32, MRD64, MWR32, MWR64, CPL, CPLD.
  - DW field bit offsets.
  - State enum.
- One natural sub-module: `pcie_tlp_hdr_fields`, a combinational header-beat field extractor.

## Test plan
- MRd32 with addr 0x0000_1004, tag 0x12, rid 0xABCD, BE 0xF:
  - `req_compl` high for 1 cycle; `req_addr`=0x1004, `req_tag`=0x12, `req_be`=0x0F.
  - tready low until `compl_done` pulses and falls.
- MWr32 to 0x20 with data 0xDEADBEEF, BE 0x3, and `wr_busy` held 3 cycles: single `wr_en` in the cycle after `wr_busy` drops, with `wr_data`=0xDEADBEEF and `wr_be`=0x3.
- Three-beat CplD followed by MRd32:
  - CplD drained.
  - `unsupported_cnt`=1.
  - MRd serviced normally.
- MWr64 to 0x1_0000_0040 with data 0x55:
  - With the macro: `wr_addr`=0x40.
  - Without the macro: no `wr_en` and `unsupported_cnt`=1.
- 300 MRd32 with len=2: no `req_compl` and `unsupported_cnt`=255.
- Reset asserted in CPL_PEND: outputs 0 immediately; after release a new MRd32 completes normally.
